// File: rtl/jtframe_pllrst_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, default
// timing constants and saturating status-counter helpers.
package jtframe_pllrst_pkg;

  typedef enum logic [2:0] {
    ST_PULSE = 3'd0,
    ST_WAIT  = 3'd1,
    ST_QUAL  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAIL  = 3'd4
  } pllrst_state_e;

  // Defaults sized for a 48 MHz reference clock
  localparam int unsigned PLLRST_RST_PULSE = 16;
  localparam int unsigned PLLRST_LOCK_TMO  = 1048576;
  localparam int unsigned PLLRST_STABLE    = 4096;
  localparam int unsigned PLLRST_MAXTRY    = 8;
  localparam int unsigned PLLRST_CW        = 21;

  localparam int unsigned TRIES_W   = 4;
  localparam int unsigned UNLOCKS_W = 8;

  function automatic logic [TRIES_W-1:0] sat_inc_tries(input logic [TRIES_W-1:0] v);
    return (&v) ? v : v + TRIES_W'(1);
  endfunction

  function automatic logic [UNLOCKS_W-1:0] sat_inc_unlocks(input logic [UNLOCKS_W-1:0] v);
    return (&v) ? v : v + UNLOCKS_W'(1);
  endfunction

endpackage

// File: rtl/jtframe_sync.sv
// Two-flop synchronizer with asynchronous active-low clear, used to bring
// the PLL lock indication into the reference clock domain.
module jtframe_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/jtframe_pllrst.sv
// PLL reset sequencer and lock monitor: pulses the PLL reset, waits for lock
// with timeout and bounded retries, qualifies lock, then releases game reset.
module jtframe_pllrst
  import jtframe_pllrst_pkg::*;
#(
  parameter int unsigned RST_PULSE = PLLRST_RST_PULSE,
  parameter int unsigned LOCK_TMO  = PLLRST_LOCK_TMO,
  parameter int unsigned STABLE    = PLLRST_STABLE,
  parameter int unsigned MAXTRY    = PLLRST_MAXTRY,
  parameter int unsigned CW        = PLLRST_CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_locked,
  output logic                 pll_rst,
  output logic                 game_rst,
  output logic                 ready,
  output logic                 fail,
  output logic [TRIES_W-1:0]   tries,
  output logic [UNLOCKS_W-1:0] unlocks
);

  localparam logic [CW-1:0]      PULSE_LAST  = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0]      TMO_LAST    = CW'(LOCK_TMO - 1);
  localparam logic [CW-1:0]      STABLE_LAST = CW'(STABLE - 1);
  localparam logic [TRIES_W-1:0] MAXTRY_L    = TRIES_W'(MAXTRY);
  localparam bit                 RETRY_EVER  = (MAXTRY == 0);

  logic locked_s;

  pllrst_state_e        state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 cnt_inc;
  logic [TRIES_W-1:0]   tries_q, tries_d;
  logic [UNLOCKS_W-1:0] unlocks_q, unlocks_d;
  logic                 pll_rst_q, pll_rst_d;
  logic                 game_rst_q, game_rst_d;
  logic                 fail_q, fail_d;

  jtframe_sync #(.W(1)) u_sync (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .d_i     (pll_locked),
    .q_o     (locked_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PULSE;
      cnt_q      <= '0;
      tries_q    <= '0;
      unlocks_q  <= '0;
      pll_rst_q  <= 1'b1;
      game_rst_q <= 1'b1;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tries_q    <= tries_d;
      unlocks_q  <= unlocks_d;
      pll_rst_q  <= pll_rst_d;
      game_rst_q <= game_rst_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    unlocks_d = unlocks_q;
    cnt_inc   = 1'b0;

    case (state_q)
      ST_PULSE: begin
        cnt_inc = 1'b1;
        if (cnt_q == PULSE_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_inc = 1'b1;
        // A lock seen on the timeout cycle still counts as a lock
        if (locked_s) begin
          state_d = ST_QUAL;
        end else if (cnt_q == TMO_LAST) begin
          tries_d = sat_inc_tries(tries_q);
          if (!RETRY_EVER && (tries_d == MAXTRY_L)) state_d = ST_FAIL;
          else                                      state_d = ST_PULSE;
        end
      end
      ST_QUAL: begin
        cnt_inc = 1'b1;
        if (!locked_s)                state_d = ST_WAIT;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d   = ST_PULSE;
          unlocks_d = sat_inc_unlocks(unlocks_q);
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_PULSE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (cnt_inc)       cnt_d = cnt_q + CW'(1);
    else                    cnt_d = cnt_q;

    // Outputs follow the next state so they move on the same edge as it
    pll_rst_d  = (state_d == ST_PULSE);
    game_rst_d = (state_d != ST_RUN);
    fail_d     = (state_d == ST_FAIL);
  end

  assign pll_rst  = pll_rst_q;
  assign game_rst = game_rst_q;
  assign ready    = ~game_rst_q;
  assign fail     = fail_q;
  assign tries    = tries_q;
  assign unlocks  = unlocks_q;

endmodule

// File: doc/jtframe_pllrst.md
# jtframe_pllrst

PLL reset sequencer and lock monitor that drives the game PLL's `rst` input and consumes its `locked` output. It pulses the PLL reset, waits for lock with a timeout and bounded retries, and qualifies lock for a stable period before releasing the core reset. It re-sequences the PLL on loss of lock and reports retry and unlock statistics to the framework status bits. It sits between the board reference clock and the PLL/game reset tree in the MiSTer target.

## Interface
- `RST_PULSE`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TMO`, 1048576: cycles allowed for lock after `pll_rst` falls (≥2).
- `STABLE`, 4096: consecutive synchronized-locked cycles required before releasing `game_rst` (≥1).
- `MAXTRY`, 8: timeout retries before entering FAIL; 0 = retry forever (≤15).
- `CW`, 21: counter width; must hold max(RST_PULSE, LOCK_TMO, STABLE).
- `clk` in 1: free-running reference clock (same source as PLL refclk, 48 MHz).
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock, asynchronous to `clk`.
- `pll_rst` out 1: PLL reset, active high.
- `game_rst` out 1: core reset, active high.
- `ready` out 1: equals `~game_rst`.
- `fail` out 1: lock never achieved within MAXTRY retries.
- `tries` out 4: timeout retries since `rst_n` (saturating).
- `unlocks` out 8: lock losses while in RUN (saturating at 255).

## Operation
- `pll_locked` goes through a 2-FF synchronizer → `locked_s`; all decisions use `locked_s` only.
- States: PULSE, WAIT, QUAL, RUN, FAIL. One counter `cnt`, cleared on every state change.
- PULSE: `pll_rst`=1, `game_rst`=1. At `cnt==RST_PULSE-1` → WAIT.
- WAIT: `pll_rst`=0. `locked_s`=1 → QUAL. Otherwise, at `cnt==LOCK_TMO-1`, `tries`++; then → FAIL if `MAXTRY!=0` and new `tries==MAXTRY`, else → PULSE. Lock and timeout in the same cycle: lock wins.
- QUAL: `locked_s`=0 → WAIT (cnt cleared, no `tries` increment, fresh timeout). Else at `cnt==STABLE-1` → RUN.
- RUN: `game_rst`=0. `locked_s`=0 → PULSE, `unlocks`++; `tries` unchanged.
- FAIL: `pll_rst`=0, `game_rst`=1, `fail`=1. Terminal until `rst_n`.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.

## Timing
- Reset values (during `rst_n`=0): state PULSE, `cnt`=0, `pll_rst`=1, `game_rst`=1, `ready`=0, `fail`=0, `tries`=0, `unlocks`=0, synchronizer flops 0.
- After `rst_n` deasserts, `pll_rst` stays high for exactly RST_PULSE rising edges.
- `pll_locked` rise to `locked_s`: 2 cycles. `locked_s` rise to `game_rst` fall: STABLE+1 cycles.
- `pll_locked` fall in RUN to `game_rst` rise: 3 cycles. `pll_rst` rises on the same edge.
- `rst_n` asserted mid-sequence: immediate asynchronous return to the reset values; counters are not preserved.
- A `locked_s` glitch shorter than STABLE in QUAL never releases `game_rst`.

## Structure
- The shared framework package/header holds the state encoding constants (3-bit: PULSE=0, WAIT=1, QUAL=2, RUN=3, FAIL=4) and the default timing constants, so the MiST/SiDi targets reuse them.
- One sub-module: `jtframe_sync`, the 2-FF synchronizer with asynchronous active-low clear. Everything else is flat in `jtframe_pllrst`.

## Test plan
- Normal lock (RST_PULSE=4, LOCK_TMO=64, STABLE=8): release `rst_n`; `pll_locked`=1 on cycle 20 → `pll_rst` high cycles 0–3; `game_rst` falls on cycle 31; `tries`=0.
- Timeout retry: `pll_locked` held 0 → `pll_rst` re-pulses every 68 cycles; `tries` counts 1,2,…; with MAXTRY=3, `fail`=1 after the third timeout, and `pll_rst`=0, `game_rst`=1 thereafter.
- Qualification glitch: `pll_locked` high 5 cycles, low 1, then high → `game_rst` stays 1; it falls 9 cycles after the final `locked_s` rise; `tries` unchanged.
- Loss in RUN: drop `pll_locked` → `game_rst` and `pll_rst` rise 3 cycles later; `unlocks`=1; relock re-releases `game_rst`. Repeat 300× → `unlocks` saturates at 255.
- Mid-sequence reset: assert `rst_n` during QUAL and during FAIL → all outputs return to reset values asynchronously, and the sequence restarts cleanly.
